score_display_ctrl: RTL



---
 rtl/score_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/score_display_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score display: segment patterns, FSM state
// encoding and the BCD-to-segment decoder.
package score_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        STORE  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one score bit per cycle, result held
// after a one-cycle done pulse until the next start.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = 5,
    parameter int DIGITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    din,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CW = $clog2(SCORE_W + 1);

    state_t               st_r;
    logic [SCORE_W-1:0]   sh_r;
    logic [4*DIGITS-1:0]  bcd_r;
    logic [4*DIGITS-1:0]  adj_s;
    logic [CW-1:0]        cnt_r;
    logic                 done_r;

    // Add-3 correction of every nibble that would overflow past 9 on shift
    always_comb begin
        adj_s = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4];
            end
        end
    end

    // Load / shift / store sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r   <= IDLE;
            sh_r   <= '0;
            bcd_r  <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (st_r)
                IDLE: begin
                    if (start) st_r <= LOAD;
                    else       st_r <= IDLE;
                end
                LOAD: begin
                    sh_r  <= din;
                    bcd_r <= '0;
                    cnt_r <= '0;
                    st_r  <= SHIFT;
                end
                SHIFT: begin
                    bcd_r <= {adj_s[4*DIGITS-2:0], sh_r[SCORE_W-1]};
                    sh_r  <= sh_r << 1;
                    if (cnt_r == CW'(SCORE_W - 1)) begin
                        st_r   <= STORE;
                        done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STORE: begin
                    if (start) st_r <= LOAD;
                    else       st_r <= IDLE;
                end
                default: st_r <= IDLE;
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign done = done_r;

endmodule

// File: rtl/score_display_ctrl.sv
// Two-player seven-segment score driver: converts both scores with one shared
// BCD engine, commits both displays together, and blinks the win LEDs.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int SCORE_W   = 5,
    parameter int DIGITS    = 2,
    parameter int LZB       = 0,
    parameter int BLINK_EN  = 1,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [SCORE_W-1:0]     SCORE1,
    input  logic [SCORE_W-1:0]     SCORE2,
    input  logic                   WIN1,
    input  logic                   WIN2,
    output logic [14*DIGITS-1:0]   HEX_D,
    output logic [2*DIGITS-1:0]    HEX_DP,
    output logic [9:0]             LEDG,
    output logic                   BUSY
);

    localparam logic [31:0]          LIMIT    = pow10(DIGITS);
    localparam int                   BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic                 BLINK_ON = (BLINK_EN != 0);
    localparam logic [2*DIGITS-1:0]  DP_ONE   = {{(2*DIGITS-1){1'b0}}, 1'b1};
    localparam logic [2*DIGITS-1:0]  DP_PAT   = ~(DP_ONE << DIGITS);

    state_t                st_r;
    logic                  p_r;
    logic                  force_r;
    logic [SCORE_W-1:0]    last1_r, last2_r;
    logic                  ovf1_r, ovf2_r;
    logic [4*DIGITS-1:0]   bcd1_r, bcd2_r, bcd_s;
    logic [14*DIGITS-1:0]  hex_r, hex_s;
    logic [2*DIGITS-1:0]   dp_r;
    logic [9:0]            ledg_r;
    logic                  busy_r;
    logic [BW-1:0]         blink_cnt_r;
    logic                  phase_r;
    logic [SCORE_W-1:0]    din_s;
    logic                  ovf_s, need_s, start_s, done_s, lit_s;

    // Operand selection, change detection and engine start
    always_comb begin
        if (p_r) din_s = SCORE2;
        else     din_s = SCORE1;
        ovf_s  = (32'(din_s) >= LIMIT);
        need_s = force_r | (SCORE1 != last1_r) | (SCORE2 != last2_r);
        if ((st_r == IDLE || st_r == COMMIT) && need_s) begin
            start_s = 1'b1;
        end else if (st_r == SHIFT && done_s && !p_r) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bcd (
        .clk   (CLK),
        .rst   (RST),
        .start (start_s),
        .din   (din_s),
        .bcd   (bcd_s),
        .done  (done_s)
    );

    // Segment image of both players; a dash run overrides everything
    always_comb begin
        logic [3:0] nib;
        logic       lead;
        logic       ovf;
        hex_s = '1;
        nib   = 4'd0;
        lead  = 1'b1;
        ovf   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            lead = 1'b1;
            if (p == 0) ovf = ovf1_r;
            else        ovf = ovf2_r;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                if (p == 0) nib = bcd1_r[4*k +: 4];
                else        nib = bcd2_r[4*k +: 4];
                if (ovf) begin
                    hex_s[7*(p*DIGITS+k) +: 7] = SEG_DASH;
                end else if ((LZB != 0) && (k != 0) && lead && (nib == 4'd0)) begin
                    hex_s[7*(p*DIGITS+k) +: 7] = SEG_BLANK;
                end else begin
                    hex_s[7*(p*DIGITS+k) +: 7] = bcd_to_seg(nib);
                end
                if (nib != 4'd0) lead = 1'b0;
            end
        end
    end

    // Conversion sequencing; a change pending at commit chains straight into the next run
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_r    <= IDLE;
            p_r     <= 1'b0;
            force_r <= 1'b1;
            last1_r <= '0;
            last2_r <= '0;
            ovf1_r  <= 1'b0;
            ovf2_r  <= 1'b0;
            bcd1_r  <= '0;
            bcd2_r  <= '0;
            hex_r   <= '1;
            busy_r  <= 1'b0;
        end else begin
            case (st_r)
                IDLE: begin
                    if (need_s) begin
                        st_r   <= LOAD;
                        p_r    <= 1'b0;
                        busy_r <= 1'b1;
                    end else begin
                        st_r   <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (p_r) begin
                        last2_r <= din_s;
                        ovf2_r  <= ovf_s;
                    end else begin
                        last1_r <= din_s;
                        ovf1_r  <= ovf_s;
                        force_r <= 1'b0;
                    end
                    st_r   <= SHIFT;
                    busy_r <= 1'b1;
                end
                SHIFT: begin
                    busy_r <= 1'b1;
                    if (done_s) begin
                        if (p_r) begin
                            bcd2_r <= bcd_s;
                            st_r   <= COMMIT;
                        end else begin
                            bcd1_r <= bcd_s;
                            p_r    <= 1'b1;
                            st_r   <= LOAD;
                        end
                    end else begin
                        st_r <= SHIFT;
                    end
                end
                COMMIT: begin
                    hex_r <= hex_s;
                    if (need_s) begin
                        st_r   <= LOAD;
                        p_r    <= 1'b0;
                        busy_r <= 1'b1;
                    end else begin
                        st_r   <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    st_r   <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign lit_s = phase_r | ~BLINK_ON;

    // Free-running blink divider, win LEDs and separator point
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            ledg_r      <= 10'd0;
            dp_r        <= '1;
        end else begin
            if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
                blink_cnt_r <= '0;
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
            ledg_r <= {{5{WIN2 & lit_s}}, {5{WIN1 & lit_s}}};
            dp_r   <= DP_PAT;
        end
    end

    assign HEX_D  = hex_r;
    assign HEX_DP = dp_r;
    assign LEDG   = ledg_r;
    assign BUSY   = busy_r;

endmodule
